// File: rtl/serial_add_ctrl.sv
// Bit-serial unsigned adder with start/abort control.
// One sum bit per clock, LSB first; result committed after WIDTH shifts.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             c_out
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;

    logic w_sbit;
    logic w_cnext;
    logic w_last;

    assign w_sbit  = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_cnext = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));
    assign w_last  = (r_cnt == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Abort is checked before completion so it wins on the final edge.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            sum_out <= '0;
            c_out   <= 1'b0;
        end else if (r_state == S_IDLE && start) begin
            r_a     <= a_in;
            r_b     <= b_in;
            r_cnt   <= '0;
            r_carry <= 1'b0;
        end else if (r_state == S_SHIFT && !abort) begin
            r_a     <= {1'b0, r_a[WIDTH-1:1]};
            r_b     <= {1'b0, r_b[WIDTH-1:1]};
            r_res   <= {w_sbit, r_res[WIDTH-1:1]};
            r_carry <= w_cnext;
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
                sum_out <= {w_sbit, r_res[WIDTH-1:1]};
                c_out   <= w_cnext;
            end
        end
    end

    assign busy = (r_state == S_SHIFT);
    assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8).
// Vector table plus hand sequences; results checked via a scoreboard queue.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         start;
    logic         abort;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         busy;
    logic         done;
    logic [W-1:0] sum_out;
    logic         c_out;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] s;
        logic         c;
    } vec_t;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
    } exp_t;

    vec_t vecs[9];
    exp_t sb[$];

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .abort   (abort),
        .a_in    (a_in),
        .b_in    (b_in),
        .busy    (busy),
        .done    (done),
        .sum_out (sum_out),
        .c_out   (c_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Scoreboard: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset && done) begin
            exp_t e;
            chk("busy_done_excl", busy, 0);
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected 0 (sum=%0d)", sum_out);
            end else begin
                e = sb.pop_front();
                chk("sb_sum", sum_out, e.s);
                chk("sb_cout", c_out, e.c);
            end
        end
    end

    // Start an op (start held until busy rises), then time it to done.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] es, input logic ec,
                          input int exp_wait);
        int  w;
        int  k;
        int  bc;
        bit  got;
        sb.push_back('{es, ec});
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        w     = 0;
        got   = 1'b0;
        while (!got && w < 5) begin
            @(posedge clk);
            #1;
            w++;
            if (busy) got = 1'b1;
        end
        start = 1'b0;
        a_in  = W'($urandom);
        b_in  = W'($urandom);
        chk("accept", got, 1);
        if (exp_wait > 0) chk("accept_edges", w, exp_wait);
        if (got) begin
            k   = 0;
            bc  = 0;
            got = 1'b0;
            while (!got && k < 20) begin
                @(negedge clk);
                k++;
                if (done) got = 1'b1;
                else if (busy) bc++;
            end
            chk("done_seen", got, 1);
            chk("latency", k, W + 1);
            chk("busy_cycles", bc, W);
        end
    endtask

    // Start an op without a scoreboard entry; returns in SHIFT cycle 1.
    task automatic start_noexp(input logic [W-1:0] a, input logic [W-1:0] b);
        int w;
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        w     = 0;
        while (!busy && w < 5) begin
            @(posedge clk);
            #1;
            w++;
        end
        start = 1'b0;
        chk("noexp_accept", busy, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nd;
        int c;
        int last;
        bit fin;

        vecs[0] = '{8'd123, 8'd32,  8'd155, 1'b0};
        vecs[1] = '{8'd200, 8'd100, 8'd44,  1'b1};
        vecs[2] = '{8'd255, 8'd1,   8'd0,   1'b1};
        vecs[3] = '{8'd0,   8'd0,   8'd0,   1'b0};
        vecs[4] = '{8'd255, 8'd255, 8'd254, 1'b1};
        vecs[5] = '{8'd170, 8'd85,  8'd255, 1'b0};
        vecs[6] = '{8'd1,   8'd255, 8'd0,   1'b1};
        vecs[7] = '{8'd128, 8'd128, 8'd0,   1'b1};
        vecs[8] = '{8'd99,  8'd27,  8'd126, 1'b0};

        reset = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        a_in  = '0;
        b_in  = '0;

        #2;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum_out, 0);
        chk("rst_cout", c_out, 0);

        #10;
        reset = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c, (i == 0) ? 1 : 0);
        end

        // start held high: a done every 10 cycles, operand churn in SHIFT
        for (int i = 0; i < 3; i++) sb.push_back('{8'd15, 1'b0});
        a_in  = 8'd3;
        b_in  = 8'd12;
        start = 1'b1;
        nd    = 0;
        c     = 0;
        last  = 0;
        fin   = 1'b0;
        while (!fin && c < 60) begin
            @(negedge clk);
            c++;
            if (done) begin
                nd++;
                if (nd > 1) chk("cont_period", c - last, 10);
                last = c;
                a_in = 8'd3;
                b_in = 8'd12;
                if (nd == 3) begin
                    start = 1'b0;
                    fin   = 1'b1;
                end
            end else if (busy) begin
                a_in = W'($urandom);
                b_in = W'($urandom);
            end else begin
                a_in = 8'd3;
                b_in = 8'd12;
            end
        end
        start = 1'b0;
        chk("cont_count", nd, 3);

        // abort in the 4th SHIFT cycle
        start_noexp(8'd16, 8'd6);
        repeat (3) @(posedge clk);
        #1;
        chk("abort4_busy_before", busy, 1);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort4_busy", busy, 0);
        chk("abort4_done", done, 0);
        chk("abort4_sum", sum_out, 15);
        repeat (12) @(negedge clk);
        chk("abort4_sum_hold", sum_out, 15);
        run_op(8'd16, 8'd6, 8'd22, 1'b0, 0);

        // abort on the final (8th) SHIFT edge
        start_noexp(8'd1, 8'd2);
        repeat (7) @(posedge clk);
        #1;
        chk("abort8_busy_before", busy, 1);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort8_busy", busy, 0);
        chk("abort8_done", done, 0);
        chk("abort8_sum", sum_out, 22);
        chk("abort8_cout", c_out, 0);
        repeat (12) @(negedge clk);
        chk("abort8_sum_hold", sum_out, 22);

        // reset asserted between edges mid-SHIFT
        start_noexp(8'd100, 8'd100);
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_sum", sum_out, 0);
        chk("midrst_cout", c_out, 0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        repeat (12) @(negedge clk);
        chk("postrst_busy", busy, 0);
        chk("postrst_sum", sum_out, 0);
        run_op(8'd7, 8'd9, 8'd16, 1'b0, 0);

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-004 SHALL have port start, input, 1, request to add a_in and b_in; sampled only in IDLE.
REQ-005 SHALL have port abort, input, 1, synchronous cancel of an in-progress addition.
REQ-006 SHALL have port a_in, input, WIDTH, operand A, unsigned.
REQ-007 SHALL have port b_in, input, WIDTH, operand B, unsigned.
REQ-008 SHALL have port busy, output, 1, high while in SHIFT.
REQ-009 SHALL have port done, output, 1, one-cycle pulse when a result is committed.
REQ-010 SHALL have port sum_out, output, WIDTH, last committed sum, A+B mod 2^WIDTH.
REQ-011 SHALL have port c_out, output, 1, carry-out of the last committed sum.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT, DONE, all registered.
REQ-013 SHALL, in IDLE with start=1 at an edge, latch a_in/b_in into internal shift registers, clear the serial carry flop and bit counter to 0, and enter SHIFT.
REQ-014 SHALL, in IDLE with start=0, remain in IDLE; a_in/b_in SHALL be ignored.
REQ-015 SHALL, on each SHIFT edge, form sum bit and next carry from the operand LSBs plus carry (full adder), shift both operand registers right by one, shift the sum bit into the MSB of an internal result register, and increment the counter.
REQ-016 SHALL, on the SHIFT edge where the counter equals WIDTH-1, load sum_out from the completed result register, load c_out from the final carry, and enter DONE.
REQ-017 SHALL drive done=1 only in DONE, exactly one cycle, then return to IDLE unconditionally.
REQ-018 SHALL have latency: start sampled at edge N -> done high and sum_out/c_out valid in the cycle after edge N+WIDTH.
REQ-019 SHALL ignore start while in SHIFT or DONE; no queuing.
REQ-020 SHALL, with abort=1 in SHIFT, return to IDLE at that edge without updating sum_out/c_out and without a done pulse.
REQ-021 SHALL give abort priority over completion when both occur on the final SHIFT edge.
REQ-022 SHALL ignore abort in IDLE and DONE.
REQ-023 SHALL hold sum_out and c_out stable from commit until the next commit.
REQ-024 SHALL make busy=1 iff state is SHIFT; busy and done never both high.
REQ-025 SHALL allow back-to-back operation: start high in the cycle following done is accepted.

Reset
REQ-026 SHALL, while reset=0, force state IDLE, busy=0, done=0, sum_out=0, c_out=0, counter, carry and internal shift registers to 0, independent of clk.
REQ-027 SHALL, on reset assertion mid-SHIFT, discard the operation; no done pulse follows deassertion.
REQ-028 SHALL accept start on the first rising edge after reset deassertion.

Verification
REQ-029 SHALL verify WIDTH=8, A=123, B=32, start one cycle -> done after 9 edges, sum_out=155, c_out=0, busy high exactly 8 cycles.
REQ-030 SHALL verify A=200, B=100 -> sum_out=44, c_out=1; then A=255, B=1 -> sum_out=0, c_out=1.
REQ-031 SHALL verify start held high continuously with A=3, B=12 -> sum_out=15 with a done every 10 cycles; operand changes during SHIFT have no effect on the result.
REQ-032 SHALL verify abort on the 4th SHIFT cycle of A=16, B=6 after a prior result of 15 -> no done, sum_out stays 15, next start with A=16, B=6 gives sum_out=22.
REQ-033 SHALL verify reset pulled low mid-SHIFT, between clock edges -> outputs 0 immediately, no done after release.
REQ-034 SHALL verify abort and completion on the same (8th) SHIFT edge -> abort wins, no done, sum_out unchanged.
